// File: rtl/debounce_pulse_gen_pkg.sv
// Shared definitions for the push-button debounce / pulse generator block.
// The state encoding is fixed so other FSM blocks and benches can reuse it.
package debounce_pulse_gen_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    CHK_PRESS = 2'b01,
    HELD      = 2'b10,
    CHK_REL   = 2'b11
  } state_t;

  // True while a candidate level change is being qualified.
  function automatic logic is_checking(input state_t st);
    return (st == CHK_PRESS) || (st == CHK_REL);
  endfunction

endpackage

// File: rtl/sync_nff.sv
// N-flop synchronizer for a single asynchronous level; resets to 0.
module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reseta,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk or posedge reseta) begin
    if (reseta) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/debounce_pulse_gen.sv
// Turns a raw bouncing push-button into a clean one-cycle enable pulse,
// with optional hold-to-repeat at a fixed rate.
module debounce_pulse_gen
  import debounce_pulse_gen_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_CYCLES   = 8,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic reseta,
  input  logic btn_in,
  input  logic repeat_en,
  output logic enable_out,
  output logic btn_level,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic             s;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             enable_n, level_n, busy_n;

  sync_nff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .reseta (reseta),
    .d      (btn_in),
    .q      (s)
  );

  always_ff @(posedge clk or posedge reseta) begin
    if (reseta) begin
      state      <= IDLE;
      cnt        <= '0;
      enable_out <= 1'b0;
      btn_level  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      enable_out <= enable_n;
      btn_level  <= level_n;
      busy       <= busy_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    enable_n = 1'b0;
    level_n  = btn_level;

    case (state)
      IDLE: begin
        if (s) begin
          state_n = CHK_PRESS;
          cnt_n   = CNT_ONE;
        end
      end
      CHK_PRESS: begin
        if (!s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n  = HELD;
          level_n  = 1'b1;
          enable_n = 1'b1;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!s) begin
          state_n = CHK_REL;
          cnt_n   = CNT_ONE;
        end else if (!repeat_en) begin
          cnt_n = '0;
        end else if (cnt == REP_LAST) begin
          enable_n = 1'b1;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      CHK_REL: begin
        // A release is accepted silently; only presses and repeats pulse.
        if (s) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == DEB_LAST) begin
          state_n = IDLE;
          level_n = 1'b0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        level_n = 1'b0;
      end
    endcase

    busy_n = is_checking(state_n);
  end

endmodule

// File: tb/tb_debounce_pulse_gen.sv
// Self-checking bench for debounce_pulse_gen: per-cycle expected outputs are
// queued when inputs are driven and compared after the following clock edge.
module tb_debounce_pulse_gen;

  logic clk = 1'b0;
  logic reseta;
  logic btn_in;
  logic repeat_en;
  logic enable_out;
  logic btn_level;
  logic busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic en;
    logic lvl;
    logic busy;
  } exp_t;

  typedef struct {
    logic btn;
    logic rep;
    logic en;
    logic lvl;
    logic busy;
  } vec_t;

  exp_t sb[$];
  vec_t press_tbl[10];

  // Counter downstream of enable_out, used for the integration test.
  logic [3:0] cq;
  logic       tc_prev;
  int         tc_rises;

  debounce_pulse_gen dut (
    .clk        (clk),
    .reseta     (reseta),
    .btn_in     (btn_in),
    .repeat_en  (repeat_en),
    .enable_out (enable_out),
    .btn_level  (btn_level),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reseta) begin
    if (reseta) begin
      cq       <= 4'd0;
      tc_prev  <= 1'b0;
      tc_rises <= 0;
    end else begin
      cq      <= cq + {3'd0, enable_out};
      tc_prev <= (cq == 4'hF);
      if ((cq == 4'hF) && !tc_prev) tc_rises <= tc_rises + 1;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare after the edge.
  task automatic step(input logic b, input logic r, input logic e_en,
                      input logic e_lvl, input logic e_busy,
                      input string tag, input int idx);
    exp_t e;
    @(negedge clk);
    btn_in    = b;
    repeat_en = r;
    sb.push_back('{en: e_en, lvl: e_lvl, busy: e_busy});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("%s[%0d].enable_out", tag, idx), int'(enable_out), int'(e.en));
    check($sformatf("%s[%0d].btn_level", tag, idx), int'(btn_level), int'(e.lvl));
    check($sformatf("%s[%0d].busy", tag, idx), int'(busy), int'(e.busy));
  endtask

  // Clean press from IDLE: busy for 3 cycles, pulse and level after edge 5.
  task automatic press(input string tag);
    for (int j = 0; j < 8; j++)
      step(1'b1, 1'b0, j == 5, j >= 5, j >= 2 && j <= 4, tag, j);
  endtask

  // Clean release from HELD: level drops after the 4th stable low sample.
  task automatic release_btn(input string tag);
    for (int j = 0; j < 7; j++)
      step(1'b0, 1'b0, 1'b0, j < 5, j >= 2 && j <= 4, tag, j);
  endtask

  initial begin
    for (int j = 0; j < 10; j++)
      press_tbl[j] = '{btn: 1'b1, rep: 1'b0, en: j == 5, lvl: j >= 5,
                       busy: j >= 2 && j <= 4};

    reseta    = 1'b1;
    btn_in    = 1'b0;
    repeat_en = 1'b0;
    #1;
    check("reset.enable_out", int'(enable_out), 0);
    check("reset.btn_level", int'(btn_level), 0);
    check("reset.busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reseta = 1'b0;

    // Clean press, no repeat: exactly one pulse.
    foreach (press_tbl[j])
      step(press_tbl[j].btn, press_tbl[j].rep, press_tbl[j].en,
           press_tbl[j].lvl, press_tbl[j].busy, "press_tbl", j);

    // Release with a one-cycle bounce back to 1.
    begin
      logic rel_btn [12] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      logic rel_busy[12] = '{0, 0, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0};
      for (int k = 0; k < 12; k++)
        step(rel_btn[k], 1'b0, 1'b0, k < 8, rel_busy[k], "release_bounce", k);
    end

    // Bounce on press: 1,0,1,0,1,0 then steady 0.
    for (int k = 0; k < 12; k++)
      step((k < 6) && (k % 2 == 0), 1'b0, 1'b0, 1'b0,
           k == 2 || k == 4 || k == 6, "press_bounce", k);

    // Auto-repeat for 40 cycles, then repeat_en dropped while still held.
    for (int k = 0; k < 52; k++)
      step(1'b1, k < 40,
           (k == 5) || (k > 5 && k < 40 && (k - 5) % 8 == 0),
           k >= 5, k >= 2 && k <= 4, "repeat", k);
    release_btn("repeat_rel");

    // Asynchronous reset in the middle of press qualification.
    for (int k = 0; k < 4; k++)
      step(1'b1, 1'b0, 1'b0, 1'b0, k >= 2, "pre_reset", k);
    #2;
    reseta = 1'b1;
    #1;
    check("async_reset.enable_out", int'(enable_out), 0);
    check("async_reset.btn_level", int'(btn_level), 0);
    check("async_reset.busy", int'(busy), 0);
    @(posedge clk);
    #3;
    reseta = 1'b0;
    press("post_reset_press");
    release_btn("post_reset_rel");

    // Integration with a 4-bit counter: 17 presses wrap it to 1.
    @(negedge clk);
    reseta = 1'b1;
    @(negedge clk);
    reseta = 1'b0;
    for (int p = 0; p < 17; p++) begin
      press($sformatf("int_press%0d", p));
      release_btn($sformatf("int_rel%0d", p));
    end
    check("counter.q_after_17", int'(cq), 1);
    check("counter.tc_rises", tc_rises, 1);
    check("scoreboard.drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_pulse_gen.md
Name: debounce_pulse_gen

Overview:
- Upstream stage of the 4-bit counter: turns a raw, bouncing push-button into a clean one-cycle enable pulse that drives the counter's enable input directly.
- Contains a synchronizer, a debounce FSM with a stability counter, and an optional hold-to-repeat generator, so a held button keeps advancing the counter at a fixed rate.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the input synchronizer (legal values >= 2)
DEBOUNCE_CYCLES, 4, consecutive equal synchronized samples required to accept a level change (legal values >= 2)
REPEAT_CYCLES, 8, period in clk cycles between auto-repeat pulses while the button is held (legal values >= 2)
CNT_W, 8, width of the internal stability/repeat counter (must hold max(DEBOUNCE_CYCLES, REPEAT_CYCLES)-1)

Ports:
clk  input  1  system clock, rising edge
reseta  input  1  asynchronous, active-high reset
btn_in  input  1  raw asynchronous push-button level, 1 = pressed
repeat_en  input  1  1 = emit repeat pulses while held; sampled synchronously
enable_out  output  1  registered single-cycle pulse; connects to counter enable
btn_level  output  1  registered debounced button level
busy  output  1  1 while a candidate level change is being qualified

Behaviour:
- Clock and reset: one clock, clk. reseta is asynchronous and active-high.
- Reset: while reseta=1, all of the following are forced to 0 immediately, regardless of clk: synchronizer flops, counter, state (IDLE), enable_out, btn_level, busy.
- Reset mid-operation: any in-progress qualification or repeat is abandoned. No pulse is emitted on reset release.
- Synchronizer: s = btn_in delayed through SYNC_STAGES flops.
- FSM states: IDLE, CHK_PRESS, HELD, CHK_REL.
- IDLE (btn_level=0):
  - s=1: go to CHK_PRESS, cnt<=1.
- CHK_PRESS (busy=1):
  - s=0: back to IDLE, cnt<=0, no pulse.
  - s=1 and cnt==DEBOUNCE_CYCLES-1: go to HELD, btn_level<=1, enable_out<=1 for one cycle, cnt<=0.
  - otherwise: cnt<=cnt+1.
- HELD (btn_level=1):
  - s=0: go to CHK_REL, cnt<=1.
  - s=1, repeat_en=1, cnt==REPEAT_CYCLES-1: enable_out<=1 for one cycle, cnt<=0.
  - s=1, repeat_en=1, otherwise: cnt<=cnt+1.
  - s=1, repeat_en=0: cnt<=0.
- CHK_REL (busy=1):
  - s=1: back to HELD, cnt<=0, no pulse.
  - s=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE, btn_level<=0, cnt<=0.
  - otherwise: cnt<=cnt+1.
- Release never generates a pulse.
- Press latency: let N be the first rising edge that samples btn_in=1, with btn_in stable high from then on. enable_out is high during the cycle after edge N+SYNC_STAGES+DEBOUNCE_CYCLES-1. With defaults, enable_out is high between edges N+5 and N+6.
- Pulse width: enable_out is never high for two consecutive cycles.
- Repeat spacing: with defaults, repeat pulses are exactly 8 cycles apart.
- First repeat: occurs REPEAT_CYCLES cycles after the press pulse.
- repeat_en deasserted during HELD: the counter clears; pulses stop the next cycle.
- Bounce: any s change during CHK_PRESS/CHK_REL returns to the prior stable state. The stability count restarts from scratch on the next change.
- Counter: unsigned, CNT_W bits, never wraps (always cleared before reaching 2^CNT_W-1).

Decomposition:
- Shared package: FSM state encoding constants (IDLE=2'b00, CHK_PRESS=2'b01, HELD=2'b10, CHK_REL=2'b11). These are reused by other FSM lab blocks and benches.
- One natural sub-module: sync_nff. It is a parameterized SYNC_STAGES-deep synchronizer with clk/reseta, reset value 0.
- The FSM and counter stay in the top module.

Test Plan:
- Reset then clean press: reseta=1 for 2 cycles, then btn_in=1 held → enable_out single pulse between edges N+5 and N+6, btn_level=1 from the same edge, no further pulses (repeat_en=0).
- Bounce rejection: btn_in toggles 1,0,1,0 every cycle for 6 cycles, then stays 0 → enable_out and btn_level remain 0 throughout, busy pulses high intermittently.
- Release debounce: from HELD, btn_in=0 for 2 cycles, 1 for 1 cycle, then 0 steady → btn_level drops only after 4 consecutive s=0 samples, no enable_out pulse.
- Auto-repeat: repeat_en=1, btn_in held 40 cycles → press pulse, then pulses every 8 cycles (4 repeats). Deassert repeat_en → pulses stop within one cycle.
- Async reset mid-qualification: assert reseta between clock edges while in CHK_PRESS → outputs 0 immediately. After release with btn_in still 1, a full DEBOUNCE_CYCLES qualification is required before the pulse.
- Integration with the counter: drive the counter's enable from enable_out, perform 17 clean presses → counter Q=0001 after wrap, TC seen high once at Q=1111.
